// File: rtl/bin_gray_enc.sv
// Binary-to-Gray encoder with a 2-entry valid/ready output buffer.
// Each accepted word is Gray-encoded and tagged with a one-bit "step" flag,
// which marks a Hamming distance of exactly 1 from the previously accepted
// word's Gray code. The buffer is a head/tail register pair. out_gray and
// out_step come straight from the head register, and in_ready depends only
// on the registered occupancy, so no combinational path crosses the block.
module bin_gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_step,
    output logic [15:0]      xfer_cnt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       occ;
    logic [WIDTH-1:0] tail_gray;
    logic             tail_step;
    logic [WIDTH-1:0] prev_gray;
    logic             first_word;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] gray_new;
    logic [WIDTH-1:0] gray_diff;
    logic             step_new;

    // Handshake decode, Gray encoding and single-bit-change detection of the incoming word
    always_comb begin
        in_ready  = (occ != 2'd2);
        out_valid = (occ != 2'd0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        gray_new  = in_bin ^ (in_bin >> 1);
        gray_diff = gray_new ^ prev_gray;
        // A power of two (non-zero, with one bit set) means distance 1; the first word has no predecessor
        step_new  = !first_word && (gray_diff != '0) && ((gray_diff & (gray_diff - ONE)) == '0);
    end

    // Occupancy: a push together with a pop leaves the occupancy unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Head entry: promote the tail on a pop from full, or load a new word when the head is free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_gray <= '0;
            out_step <= 1'b0;
        end else if (pop && (occ == 2'd2)) begin
            out_gray <= tail_gray;
            out_step <= tail_step;
        end else if (push && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
            out_gray <= gray_new;
            out_step <= step_new;
        end
    end

    // Tail entry: written only when the head is occupied and is not leaving this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_gray <= '0;
            tail_step <= 1'b0;
        end else if (push && (occ == 2'd1) && !pop) begin
            tail_gray <= gray_new;
            tail_step <= step_new;
        end
    end

    // History of the last accepted word, used for the step flag of the next word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray  <= '0;
            first_word <= 1'b1;
        end else if (push) begin
            prev_gray  <= gray_new;
            first_word <= 1'b0;
        end
    end

    // Completed output transfers; wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= 16'd0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule
